debounce_edge: RTL and testbench

//  Consumes an asynchronous single-bit input (button/switch/external strobe) downstream of the flip-flop stage.

---
 rtl/debounce_edge_pkg.sv | 11 +
 rtl/debounce_edge_sync_2ff.sv | 29 ++
 rtl/debounce_edge.sv | 116 +++++++++++
 tb/tb_debounce_edge.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared definitions for the debounce_edge slice: FSM state encoding.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_edge_sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic Din,
    output logic Dout
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = Din;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign Dout = s2_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronizes Din, accepts a new level after STABLE_CYCLES
// consecutive differing samples, and emits registered level plus edge pulses.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic Din,
    output logic Dout,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sq;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_2ff u_sync (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .Dout (sq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            IDLE_LO: begin
                dout_d = 1'b0;
                if (sq) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                dout_d = 1'b0;
                if (!sq) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                dout_d = 1'b1;
                if (!sq) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                dout_d = 1'b1;
                if (sq) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign Dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: directed scenarios then random bursts.
module tb_debounce_edge;

    localparam int unsigned SC = 4;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Din = 1'b1;
    logic Dout, rise, fall;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   dut_rises = 0;
    int   dut_falls = 0;
    int   mdl_rises = 0;
    int   mdl_falls = 0;

    // Reference model: sq is Din two samples late; Dout flips after SC
    // consecutive samples of sq that disagree with it.
    bit   dq[$];
    bit   m_dout = 1'b0;
    int   m_run  = 0;

    debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .Dout (Dout),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_edge(input bit r, input bit d);
        exp_t e;
        bit   sq;
        e = '0;
        if (r) begin
            dq     = {};
            dq.push_back(1'b0);
            dq.push_back(1'b0);
            m_dout = 1'b0;
            m_run  = 0;
        end else begin
            sq = dq.pop_front();
            dq.push_back(d);
            if (sq != m_dout) m_run++;
            else              m_run = 0;
            if (m_run == SC) begin
                m_dout = ~m_dout;
                m_run  = 0;
                if (m_dout) begin e.rise = 1'b1; mdl_rises++; end
                else        begin e.fall = 1'b1; mdl_falls++; end
            end
        end
        e.dout = m_dout;
        return e;
    endfunction

    task automatic step(input bit r, input bit d);
        @(negedge clk);
        #1;
        rst = r;
        Din = d;
        exp_q.push_back(model_edge(r, d));
    endtask

    task automatic hold(input bit d, input int n);
        for (int i = 0; i < n; i++) step(1'b0, d);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: each cycle the DUT presents a registered output sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{dout,rise,fall}", int'({Dout, rise, fall}), int'(e));
                if (rise) dut_rises++;
                if (fall) dut_falls++;
                if (rise && fall) check("rise_fall_exclusive", 1, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with Din high, then acquisition after release.
        // The first step only aligns stimulus after time 0; rst stays high.
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold(1'b1, 8);
        // Fall with Din held low.
        hold(1'b0, 10);
        // Clean rise.
        hold(1'b1, 10);
        hold(1'b0, 10);
        // 1-, 2-, 3-cycle high glitches.
        for (int g = 1; g <= 3; g++) begin
            hold(1'b1, g);
            hold(1'b0, 6);
        end
        // Bounce then steady high.
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Reset on the edge where WAIT_HI would complete.
        hold(1'b1, 5);
        step(1'b1, 1'b1);
        hold(1'b1, 8);
        hold(1'b0, 10);

        // Random bursts of varying length with occasional reset.
        for (int n = 0; n < 400; n++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 2 * SC + 2));
            if ($urandom_range(0, 49) == 0) step(1'b1, lvl);
            hold(lvl, len);
        end

        hold(1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("rise_pulse_count", dut_rises, mdl_rises);
        check("fall_pulse_count", dut_falls, mdl_falls);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
